// File: rtl/h14rx_timings_video.sv
// h14rx_timings_video: HDMI 1.4 sink video period tracker with pixel coordinates and geometry lock.
// Define H14RX_TIMINGS_CHECK_EN to enable the sticky err flag and error-driven lock loss.
package h14tx_pkg;
    typedef enum logic [1:0] {
        Control       = 2'd0,
        VideoPreamble = 2'd1,
        VideoGuard    = 2'd2,
        VideoActive   = 2'd3
    } period_t;
endpackage

module h14rx_timings_video
    import h14tx_pkg::*;
#(
    parameter int BitWidth    = 11,
    parameter int BitHeight   = 10,
    parameter int PreambleLen = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 is_ctl,
    input  logic [3:0]           ctl,
    input  logic                 vsync,
    input  logic                 is_vguard,
    output period_t              timings,
    output logic [BitWidth-1:0]  x,
    output logic [BitHeight-1:0] y,
    output logic [BitWidth-1:0]  line_width,
    output logic [BitHeight-1:0] frame_height,
    output logic                 locked,
    output logic                 err
);
    localparam int PcW = $clog2(PreambleLen + 1);

    typedef enum logic [1:0] {S_CTRL, S_PRE, S_GUARD, S_ACTIVE} state_t;

    state_t               r_state, w_state_next;
    period_t              r_timings, w_timings_next;
    logic [PcW-1:0]       r_pcnt;
    logic [BitWidth-1:0]  r_pix_cnt, r_x, r_line_width;
    logic [BitHeight-1:0] r_y, r_frame_height, w_y_line;
    logic                 r_locked, r_frame_ok, r_vsync_prev;
    logic                 w_pre_char, w_pcnt_full, w_vs_rise, w_err_evt, w_pixel, w_line_end;
    logic                 w_line_ok, w_width_bad, w_frame_ok, w_locked_next, w_lock_err;

    always_comb begin
        w_pre_char     = is_ctl && (ctl == 4'b0001);
        w_pcnt_full    = (r_pcnt >= PcW'(PreambleLen));
        w_vs_rise      = is_ctl && vsync && !r_vsync_prev;
        w_state_next   = r_state;
        w_timings_next = Control;
        w_err_evt      = 1'b0;
        w_pixel        = 1'b0;
        w_line_end     = 1'b0;
        case (r_state)
            S_CTRL: begin
                if (w_pre_char)
                    w_state_next = S_PRE;
                else if (!is_ctl && is_vguard)
                    w_err_evt = 1'b1;
            end
            S_PRE: begin
                if (is_ctl) begin
                    if (!w_pre_char)
                        w_state_next = S_CTRL;
                end else if (is_vguard && w_pcnt_full) begin
                    w_state_next   = S_GUARD;
                    w_timings_next = VideoGuard;
                end else begin
                    // Short preamble before a guard, or data after a full preamble, is a protocol break
                    w_state_next = S_CTRL;
                    w_err_evt    = is_vguard || w_pcnt_full;
                end
            end
            S_GUARD: begin
                if (!is_ctl && is_vguard) begin
                    w_state_next   = S_ACTIVE;
                    w_timings_next = VideoGuard;
                end else begin
                    w_state_next = S_CTRL;
                    w_err_evt    = 1'b1;
                end
            end
            default: begin
                if (is_ctl) begin
                    w_state_next = S_CTRL;
                    w_line_end   = 1'b1;
                    w_err_evt    = (r_pix_cnt == '0);
                end else begin
                    w_pixel        = 1'b1;
                    w_timings_next = VideoActive;
                end
            end
        endcase
        if (r_state != S_ACTIVE && w_pre_char)
            w_timings_next = VideoPreamble;

        // Line end is applied before a coincident vsync edge so the frame includes that line
        w_line_ok     = w_line_end && (r_pix_cnt != '0);
        w_y_line      = (w_line_ok && r_y != '1) ? r_y + BitHeight'(1) : r_y;
        w_width_bad   = w_line_ok && (r_pix_cnt != r_line_width);
        w_frame_ok    = r_frame_ok && !w_width_bad && !w_lock_err;
        w_locked_next = r_locked && !w_width_bad && !w_lock_err;
        if (w_vs_rise && w_y_line != '0)
            w_locked_next = (w_y_line == r_frame_height) && w_frame_ok;
    end

`ifdef H14RX_TIMINGS_CHECK_EN
    logic r_err;
    assign w_lock_err = w_err_evt;
    assign err        = r_err;
`else
    assign w_lock_err = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_CTRL;
            r_timings      <= Control;
            r_pcnt         <= '0;
            r_pix_cnt      <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_line_width   <= '0;
            r_frame_height <= '0;
            r_locked       <= 1'b0;
            r_frame_ok     <= 1'b1;
            r_vsync_prev   <= 1'b0;
`ifdef H14RX_TIMINGS_CHECK_EN
            r_err          <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_timings <= w_timings_next;
            if (w_pre_char) begin
                if (r_state != S_PRE)
                    r_pcnt <= PcW'(1);
                else if (!w_pcnt_full)
                    r_pcnt <= r_pcnt + PcW'(1);
            end
            if (r_state == S_GUARD)
                r_pix_cnt <= '0;
            else if (w_pixel && r_pix_cnt != '1)
                r_pix_cnt <= r_pix_cnt + BitWidth'(1);
            if (w_pixel)
                r_x <= r_pix_cnt;
            if (w_line_ok)
                r_line_width <= r_pix_cnt;
            if (is_ctl)
                r_vsync_prev <= vsync;
            r_y <= w_vs_rise ? '0 : w_y_line;
            if (w_vs_rise && w_y_line != '0)
                r_frame_height <= w_y_line;
            r_frame_ok <= w_vs_rise ? 1'b1 : w_frame_ok;
            r_locked   <= w_locked_next;
`ifdef H14RX_TIMINGS_CHECK_EN
            r_err      <= r_err || w_err_evt;
`endif
        end
    end

    assign timings      = r_timings;
    assign x            = r_x;
    assign y            = r_y;
    assign line_width   = r_line_width;
    assign frame_height = r_frame_height;
    assign locked       = r_locked;
endmodule
